// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared geometry, FSM state encoding and the line-address
//               helper for the data-cache sequencer.
//               Geometry:
//                 LINE_LENGTH  cache line length in bytes
//                 NLINES       number of direct-mapped lines
//                 PA           physical address width
//                 NNIB         nibbles per line burst (two per byte)
// Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

  localparam int LINE_LENGTH = 4;
  localparam int NLINES      = 4;
  localparam int PA          = 22;

  localparam int NNIB      = LINE_LENGTH * 2;
  localparam int OFFS_BITS = $clog2(LINE_LENGTH);
  localparam int IDX_BITS  = $clog2(NLINES);
  localparam int TAG_BITS  = PA - OFFS_BITS;
  localparam int CNT_BITS  = $clog2(NNIB);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOOKUP    = 4'd1,
    S_PUSH_REQ  = 4'd2,
    S_PUSH_XFER = 4'd3,
    S_PULL_REQ  = 4'd4,
    S_PULL_XFER = 4'd5,
    S_DONE      = 4'd6,
    S_FL_SCAN   = 4'd7,
    S_FL_REQ    = 4'd8,
    S_FL_XFER   = 4'd9,
    S_FL_CLR    = 4'd10
  } state_t;

  // Byte address of the first byte of the line named by a line tag.
  function automatic logic [PA-1:0] line_addr(input logic [TAG_BITS-1:0] tag);
    return {tag, {OFFS_BITS{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Sequencer for the write-back data cache and its 4-bit
//               line-transfer bus. Runs one CPU access at a time: lookup,
//               optional dirty-line push burst, line pull burst, re-lookup,
//               completion. Also runs a whole-cache flush (push every dirty
//               line, then invalidate all).
// Ports       : clk, reset              clock, synchronous active-high reset
//               cpu_*                   CPU request / ack handshake
//               flush_req, flush_done   whole-cache flush handshake
//               dc_*                    control/status to and from the cache
//               mem_*                   burst request and nibble timing
// Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [PA-1:0]       cpu_addr,
  input  logic                cpu_write,
  input  logic                cpu_byte,
  input  logic                cpu_fault,
  output logic                cpu_ack,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [PA-1:0]       dc_paddr,
  output logic                dc_write,
  output logic                dc_fault,
  output logic                dc_flush_write,
  output logic                dc_flush_all,
  output logic                dc_wstrobe,
  output logic                dc_rstrobe,
  input  logic                dc_hit,
  input  logic                dc_push,
  input  logic                dc_pull,
  input  logic [TAG_BITS-1:0] dc_tag,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [PA-1:0]       mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_nib
);

  state_t              r_state;
  logic [PA-1:0]       r_addr;
  logic [PA-1:0]       r_mem_addr;
  logic                r_write;
  logic                r_fault;
  logic [CNT_BITS-1:0] r_cnt;
  logic [IDX_BITS-1:0] r_idx;

  logic                w_last_nib;
  logic                w_in_flush;
  logic [PA-1:0]       w_idx_addr;

  // Byte/word select and the pull request are consumed by the cache itself;
  // the sequence of states does not depend on them (a lookup that neither
  // hits nor needs a push is by definition a pull).
  logic                w_unused_inputs;
  assign w_unused_inputs = cpu_byte ^ dc_pull;

  assign w_last_nib = mem_nib && (r_cnt == CNT_BITS'(NNIB - 1));
  assign w_idx_addr = {{(PA - IDX_BITS - OFFS_BITS){1'b0}}, r_idx, {OFFS_BITS{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_idx   <= '0;
            r_state <= S_FL_SCAN;
          end else if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_write <= cpu_write;
            r_fault <= cpu_fault;
            r_state <= cpu_fault ? S_DONE : S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (dc_hit) begin
            r_state <= S_DONE;
          end else if (dc_push) begin
            r_mem_addr <= line_addr(dc_tag);
            r_state    <= S_PUSH_REQ;
          end else begin
            r_mem_addr <= line_addr(dc_tag);
            r_state    <= S_PULL_REQ;
          end
        end
        S_PUSH_REQ: if (mem_gnt) begin r_cnt <= '0; r_state <= S_PUSH_XFER; end
        S_PULL_REQ: if (mem_gnt) begin r_cnt <= '0; r_state <= S_PULL_XFER; end
        S_FL_REQ:   if (mem_gnt) begin r_cnt <= '0; r_state <= S_FL_XFER;   end
        // The counter wraps to zero on the last nibble of a burst.
        S_PUSH_XFER: if (mem_nib) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_nib) r_state <= S_LOOKUP;
        end
        S_PULL_XFER: if (mem_nib) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_nib) r_state <= S_LOOKUP;
        end
        // After a flush push, rescan the same index: the line is now clean.
        S_FL_XFER: if (mem_nib) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_nib) r_state <= S_FL_SCAN;
        end
        S_DONE: begin
          r_fault <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FL_SCAN: begin
          if (dc_push) begin
            r_mem_addr <= line_addr(dc_tag);
            r_state    <= S_FL_REQ;
          end else if (r_idx == IDX_BITS'(NLINES - 1)) begin
            r_state <= S_FL_CLR;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FL_CLR: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // During the whole flush the cache is addressed by line index so that it
  // knows which line to drain; otherwise by the latched CPU address.
  assign w_in_flush = (r_state == S_FL_SCAN) || (r_state == S_FL_REQ) ||
                      (r_state == S_FL_XFER) || (r_state == S_FL_CLR);

  assign dc_paddr       = w_in_flush ? w_idx_addr : r_addr;
  assign cpu_ack        = (r_state == S_DONE);
  assign dc_fault       = (r_state == S_DONE) && r_fault;
  assign flush_done     = (r_state == S_FL_CLR);
  assign dc_flush_all   = (r_state == S_FL_CLR);
  assign dc_flush_write = (r_state == S_FL_SCAN);
  assign dc_write       = (r_state == S_LOOKUP) && dc_hit && r_write;
  assign mem_req        = (r_state == S_PUSH_REQ) || (r_state == S_PULL_REQ) ||
                          (r_state == S_FL_REQ);
  assign mem_wr         = (r_state == S_PUSH_REQ) || (r_state == S_PUSH_XFER) ||
                          (r_state == S_FL_REQ)   || (r_state == S_FL_XFER);
  assign mem_addr       = r_mem_addr;
  // Nibble strobes follow mem_nib in the same cycle.
  assign dc_rstrobe     = ((r_state == S_PUSH_XFER) || (r_state == S_FL_XFER)) && mem_nib;
  assign dc_wstrobe     = (r_state == S_PULL_XFER) && mem_nib;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl. A small tag-array model
//               answers lookups, a memory responder serves bursts, and a
//               scoreboard of expected bursts is checked at every grant.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                cpu_req, cpu_write, cpu_byte, cpu_fault, cpu_ack;
  logic [PA-1:0]       cpu_addr;
  logic                flush_req, flush_done;
  logic [PA-1:0]       dc_paddr;
  logic                dc_write, dc_fault, dc_flush_write, dc_flush_all;
  logic                dc_wstrobe, dc_rstrobe;
  logic                dc_hit, dc_push, dc_pull;
  logic [TAG_BITS-1:0] dc_tag;
  logic                mem_req, mem_wr, mem_gnt, mem_nib;
  logic [PA-1:0]       mem_addr;

  // Cache tag-array model
  logic                m_valid [NLINES];
  logic                m_dirty [NLINES];
  logic [TAG_BITS-1:0] m_tag   [NLINES];
  logic [IDX_BITS-1:0] m_idx;

  logic [PA:0] exp_q [$];   // expected bursts {wr, line address}
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nb, dcw_cnt, dcw_cyc, ack_cyc, fd_cyc;
  int w_hist [8];
  int r_hist [8];
  bit req_seen, ack_fault;

  dcache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_byte(cpu_byte), .cpu_fault(cpu_fault), .cpu_ack(cpu_ack),
    .flush_req(flush_req), .flush_done(flush_done),
    .dc_paddr(dc_paddr), .dc_write(dc_write), .dc_fault(dc_fault),
    .dc_flush_write(dc_flush_write), .dc_flush_all(dc_flush_all),
    .dc_wstrobe(dc_wstrobe), .dc_rstrobe(dc_rstrobe),
    .dc_hit(dc_hit), .dc_push(dc_push), .dc_pull(dc_pull), .dc_tag(dc_tag),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_nib(mem_nib)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_idx   = dc_paddr[OFFS_BITS +: IDX_BITS];
    dc_hit  = 1'b0;
    dc_push = 1'b0;
    dc_pull = 1'b0;
    dc_tag  = dc_paddr[PA-1:OFFS_BITS];
    if (dc_flush_write) begin
      dc_push = m_valid[m_idx] && m_dirty[m_idx];
      dc_tag  = m_tag[m_idx];
    end else if (m_valid[m_idx] && (m_tag[m_idx] == dc_paddr[PA-1:OFFS_BITS])) begin
      dc_hit = 1'b1;
    end else if (m_valid[m_idx] && m_dirty[m_idx]) begin
      dc_push = 1'b1;
      dc_tag  = m_tag[m_idx];
    end else begin
      dc_pull = 1'b1;
    end
  end

  function automatic logic [PA:0] burst(input logic wr, input logic [PA-1:0] a);
    return {wr, a};
  endfunction

  // Memory side: a stray nibble in the request cycle (must be ignored), a
  // grant one cycle later, then NNIB nibbles with a couple of idle gaps.
  task automatic mem_responder();
    forever begin
      @(negedge clk); #1;
      mem_gnt = 1'b0;
      mem_nib = 1'b0;
      if (!reset && mem_req) begin
        mem_nib = 1'b1;
        @(negedge clk); #1;
        mem_nib = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk); #1;
        mem_gnt = 1'b0;
        for (int i = 0; i < NNIB && !reset; i++) begin
          mem_nib = 1'b1;
          @(negedge clk); #1;
          mem_nib = 1'b0;
          if (i == 2 || i == 5) begin @(negedge clk); #1; end
        end
      end
    end
  endtask

  // Observes the DUT mid-cycle, updates the tag model and checks bursts.
  task automatic monitor();
    logic [PA:0]         e;
    logic [IDX_BITS-1:0] li;
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (reset) continue;
      li = dc_paddr[OFFS_BITS +: IDX_BITS];
      if (mem_req) req_seen = 1'b1;
      if (mem_req && mem_gnt) begin
        nb++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL burst_order: got wr=%0b addr=%06h, required no burst", mem_wr, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if ({mem_wr, mem_addr} !== e) begin
            bad++;
            $display("FAIL burst_order: got wr=%0b addr=%06h, required wr=%0b addr=%06h",
                     mem_wr, mem_addr, e[PA], e[PA-1:0]);
          end
        end
      end
      if (dc_wstrobe && nb > 0 && nb <= 8) begin
        w_hist[nb-1]++;
        if (w_hist[nb-1] == NNIB) begin
          m_valid[li] = 1'b1;
          m_dirty[li] = 1'b0;
          m_tag[li]   = dc_paddr[PA-1:OFFS_BITS];
        end
      end
      if (dc_rstrobe && nb > 0 && nb <= 8) begin
        r_hist[nb-1]++;
        if (r_hist[nb-1] == NNIB) m_dirty[li] = 1'b0;
      end
      if (dc_write) begin
        m_dirty[li] = 1'b1;
        dcw_cnt++;
        dcw_cyc = cyc;
      end
      if (dc_flush_all) foreach (m_valid[i]) m_valid[i] = 1'b0;
      if (dc_flush_all || flush_done) begin
        total++;
        if (dc_flush_all !== flush_done) begin
          bad++;
          $display("FAIL flush_all_vs_done: got flush_all=%0b flush_done=%0b, required equal",
                   dc_flush_all, flush_done);
        end
        if (flush_done) fd_cyc = cyc;
      end
      if (cpu_ack) begin
        ack_cyc   = cyc;
        ack_fault = dc_fault;
      end
    end
  endtask

  task automatic clear_obs();
    nb = 0;
    foreach (w_hist[i]) begin w_hist[i] = 0; r_hist[i] = 0; end
    dcw_cnt = 0; dcw_cyc = -1; ack_cyc = -1; fd_cyc = -1;
    req_seen = 1'b0; ack_fault = 1'b0;
  endtask

  // Issues one access (optionally with flush_req in the same cycle) and
  // waits for cpu_ack; lat is cycles from the request cycle to the ack.
  task automatic cpu_access(input logic [PA-1:0] a, input logic wr, input logic flt,
                            input logic with_flush, output int lat);
    int  start;
    bit  ok;
    @(negedge clk);
    cpu_addr  = a;
    cpu_write = wr;
    cpu_fault = flt;
    cpu_req   = 1'b1;
    flush_req = with_flush;
    #4;
    start = cyc;
    ok    = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      flush_req = 1'b0;
      #4;
      if (ack_cyc >= start) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ack_timeout: got no ack for addr %06h, required ack", a);
    end
    lat = ok ? (ack_cyc - start) : -1;
    @(negedge clk);
    cpu_req   = 1'b0;
    cpu_fault = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic check_q_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d bursts outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #4;
    total++;
    if ({cpu_ack, flush_done, dc_write, dc_fault, dc_flush_write, dc_flush_all,
         dc_wstrobe, dc_rstrobe, mem_req, mem_wr} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, required 0", {cpu_ack, flush_done, dc_write, dc_fault,
               dc_flush_write, dc_flush_all, dc_wstrobe, dc_rstrobe, mem_req, mem_wr});
    end
    total++;
    if (dc_paddr !== '0) begin bad++; $display("FAIL reset_paddr: got %06h, required 0", dc_paddr); end
    total++;
    if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %06h, required 0", mem_addr); end
  endtask

  task automatic test_load_hit();
    int lat;
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; end
    m_valid[0] = 1'b1;
    m_tag[0]   = 20'h00010;   // line 0x000040
    clear_obs();
    cpu_access(22'h000042, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL hit_latency: got %0d, required 2", lat); end
    total++;
    if (req_seen !== 1'b0) begin bad++; $display("FAIL hit_no_mem: got mem_req=1, required 0"); end
    total++;
    if (dcw_cnt !== 0) begin bad++; $display("FAIL hit_no_write: got %0d, required 0", dcw_cnt); end
    check_q_empty("hit_queue");
  endtask

  task automatic test_clean_miss();
    int lat;
    clear_obs();
    exp_q.push_back(burst(1'b0, 22'h000100));
    cpu_access(22'h000100, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (w_hist[0] !== NNIB) begin bad++; $display("FAIL miss_wstrobes: got %0d, required %0d", w_hist[0], NNIB); end
    total++;
    if (r_hist[0] !== 0) begin bad++; $display("FAIL miss_rstrobes: got %0d, required 0", r_hist[0]); end
    total++;
    if (nb !== 1) begin bad++; $display("FAIL miss_bursts: got %0d, required 1", nb); end
    check_q_empty("miss_queue");
  endtask

  task automatic test_dirty_victim();
    int lat;
    m_valid[0] = 1'b1;
    m_dirty[0] = 1'b1;
    m_tag[0]   = 20'h00004;   // line 0x000010
    clear_obs();
    exp_q.push_back(burst(1'b1, 22'h000010));
    exp_q.push_back(burst(1'b0, 22'h000110));
    cpu_access(22'h000110, 1'b1, 1'b0, 1'b0, lat);
    total++;
    if (r_hist[0] !== NNIB || w_hist[0] !== 0) begin
      bad++; $display("FAIL victim_push: got r=%0d w=%0d, required r=%0d w=0", r_hist[0], w_hist[0], NNIB);
    end
    total++;
    if (w_hist[1] !== NNIB || r_hist[1] !== 0) begin
      bad++; $display("FAIL victim_pull: got w=%0d r=%0d, required w=%0d r=0", w_hist[1], r_hist[1], NNIB);
    end
    total++;
    if (dcw_cnt !== 1) begin bad++; $display("FAIL victim_write: got %0d, required 1", dcw_cnt); end
    total++;
    if (!(dcw_cyc >= 0 && dcw_cyc < ack_cyc)) begin
      bad++; $display("FAIL victim_write_order: got write cyc %0d ack cyc %0d, required write first", dcw_cyc, ack_cyc);
    end
    check_q_empty("victim_queue");
  endtask

  task automatic test_fault();
    int lat;
    clear_obs();
    cpu_access(22'h003000, 1'b1, 1'b1, 1'b0, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL fault_latency: got %0d, required 1", lat); end
    total++;
    if (ack_fault !== 1'b1) begin bad++; $display("FAIL fault_forward: got %0b, required 1", ack_fault); end
    total++;
    if (req_seen !== 1'b0 || dcw_cnt !== 0) begin
      bad++; $display("FAIL fault_no_action: got mem_req_seen=%0b writes=%0d, required 0 0", req_seen, dcw_cnt);
    end
  endtask

  task automatic test_flush();
    int lat;
    m_valid[0] = 1'b1; m_dirty[0] = 1'b0; m_tag[0] = 20'h00010;
    m_valid[1] = 1'b1; m_dirty[1] = 1'b1; m_tag[1] = 20'h12345;
    m_valid[2] = 1'b0; m_dirty[2] = 1'b0; m_tag[2] = 20'h00000;
    m_valid[3] = 1'b1; m_dirty[3] = 1'b1; m_tag[3] = 20'h0ABCF;
    clear_obs();
    exp_q.push_back(burst(1'b1, 22'h048D14));
    exp_q.push_back(burst(1'b1, 22'h02AF3C));
    exp_q.push_back(burst(1'b0, 22'h000040));
    cpu_access(22'h000040, 1'b0, 1'b0, 1'b1, lat);
    total++;
    if (r_hist[0] !== NNIB || r_hist[1] !== NNIB) begin
      bad++; $display("FAIL flush_push_len: got %0d %0d, required %0d", r_hist[0], r_hist[1], NNIB);
    end
    total++;
    if (!(fd_cyc >= 0 && fd_cyc < ack_cyc)) begin
      bad++; $display("FAIL flush_first: got done cyc %0d ack cyc %0d, required done before ack", fd_cyc, ack_cyc);
    end
    total++;
    if (nb !== 3) begin bad++; $display("FAIL flush_bursts: got %0d, required 3", nb); end
    check_q_empty("flush_queue");
  endtask

  task automatic test_reset_mid_pull();
    int lat;
    bit ok;
    clear_obs();
    exp_q.push_back(burst(1'b0, 22'h000200));
    @(negedge clk);
    cpu_addr = 22'h000200; cpu_write = 1'b0; cpu_fault = 1'b0; cpu_req = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #4;
      if (nb >= 1 && w_hist[0] >= 4) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_reach: got %0d nibbles, required 4", w_hist[0]); end
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #4;
    total++;
    if (mem_req !== 1'b0 || dc_wstrobe !== 1'b0 || cpu_ack !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got req=%0b wstrobe=%0b ack=%0b, required 0 0 0", mem_req, dc_wstrobe, cpu_ack);
    end
    total++;
    if (mem_addr !== '0) begin bad++; $display("FAIL abort_mem_addr: got %06h, required 0", mem_addr); end
    repeat (4) @(negedge clk);
    clear_obs();
    exp_q.push_back(burst(1'b0, 22'h000200));
    cpu_access(22'h000200, 1'b0, 1'b0, 1'b0, lat);
    total++;
    if (w_hist[0] !== NNIB) begin bad++; $display("FAIL abort_repull: got %0d, required %0d", w_hist[0], NNIB); end
    check_q_empty("abort_queue");
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cpu_write = 1'b0; cpu_byte = 1'b0; cpu_fault = 1'b0;
    flush_req = 1'b0; mem_gnt = 1'b0; mem_nib = 1'b0;
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; end
    clear_obs();
    fork
      mem_responder();
      monitor();
    join_none
    test_reset();
    test_load_hit();
    test_clean_miss();
    test_dirty_victim();
    test_fault();
    test_flush();
    test_reset_mid_pull();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
